game_sequencer: RTL and testbench

Central sequencer for the dinosaur game. Replaces the raw divided clock with a single-clock tick enable, runs the IDLE/RUN/HIT/OVER game state machine and turns the up button into start and jump requests. Maintains the 4-digit BCD score and high score that feed the seven-segment scan logic. Sits between the board inputs, `block_controller` and the SSD driver in `vga_top`.

---
 rtl/game_pkg.sv | 34 +++
 rtl/bcd_counter4.sv | 34 +++
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dinosaur game sequencer: state encodings,
// score limit, default tick divider and a packed-BCD increment helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    localparam logic [15:0] BCD_MAX          = 16'h9999;
    localparam int          TICK_DIV_DEFAULT = 524288;

    // Ripple a +1 through four BCD digits; 9 rolls to 0 and carries onward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD counter with synchronous clear and an increment
// enable; holds at 9999 instead of wrapping.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);
    import game_pkg::*;

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != BCD_MAX)) begin
            count_d = bcd_inc(count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/game_sequencer.sv
// Dinosaur game sequencer: tick enable, IDLE/RUN/HIT/OVER state machine,
// button press detection and BCD score. GAME_SEQ_HISCORE_EN builds the high score.
module game_sequencer #(
    parameter int TICK_DIV   = game_pkg::TICK_DIV_DEFAULT,
    parameter int SCORE_DIV  = 8,
    parameter int DEAD_TICKS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        collision,
    output logic        move_tick,
    output logic        jump_req,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [15:0] hiscore
);
    import game_pkg::*;

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCORE_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TICKS - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    sync_q, sync_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dead_q, dead_d;
    game_state_e   state_q, state_d;
    logic          move_tick_q, move_tick_d;
    logic          jump_req_q, jump_req_d;

    logic          tick;
    logic          press;
    logic          score_clr;
    logic          score_inc;
    logic [15:0]   score_cnt;

    // Free-running divider; never restarted by game events.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // sync_q[1] is the synchronized level, sync_q[2] its previous value.
    always_comb begin
        sync_d = {sync_q[1:0], btn_up};
    end

    assign press = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        dead_d      = dead_q;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        move_tick_d = tick && (state_q == ST_RUN);
        jump_req_d  = press && (state_q == ST_RUN);
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    state_d   = ST_RUN;
                    presc_d   = '0;
                    score_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (collision) begin
                        state_d = ST_HIT;
                        dead_d  = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d   = '0;
                        score_inc = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            ST_HIT: begin
                if (tick) begin
                    if (dead_q == DEAD_LAST) begin
                        state_d = ST_OVER;
                    end else begin
                        dead_d = dead_q + DW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            sync_q      <= '0;
            presc_q     <= '0;
            dead_q      <= '0;
            state_q     <= ST_IDLE;
            move_tick_q <= 1'b0;
            jump_req_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sync_q      <= sync_d;
            presc_q     <= presc_d;
            dead_q      <= dead_d;
            state_q     <= state_d;
            move_tick_q <= move_tick_d;
            jump_req_q  <= jump_req_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score_cnt)
    );

`ifdef GAME_SEQ_HISCORE_EN
    logic [15:0] hiscore_q, hiscore_d;
    logic        hit_entry;

    // Score is frozen on the colliding tick, so score_cnt is the final score.
    assign hit_entry = (state_q == ST_RUN) && tick && collision;

    always_comb begin
        hiscore_d = hiscore_q;
        if (hit_entry && (score_cnt > hiscore_q)) begin
            hiscore_d = score_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q <= '0;
        end else begin
            hiscore_q <= hiscore_d;
        end
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = 16'h0000;
`endif

    assign move_tick = move_tick_q;
    assign jump_req  = jump_req_q;
    assign state     = state_q;
    assign score     = score_cnt;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: scenario tasks plus randomized play checked
// against an event-level game model; a second fast instance covers saturation.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int SCORE_DIV  = 2;
    localparam int DEAD_TICKS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        collision = 1'b0;
    logic        move_tick, jump_req;
    logic [1:0]  state;
    logic [15:0] score, hiscore;

    logic        btn2 = 1'b0;
    logic        coll2 = 1'b0;
    logic        s2_move, s2_jump;
    logic [1:0]  s2_state;
    logic [15:0] s2_score, s2_hi;

    logic [35:0] dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .SCORE_DIV  (SCORE_DIV),
        .DEAD_TICKS (DEAD_TICKS)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .collision (collision),
        .move_tick (move_tick),
        .jump_req  (jump_req),
        .state     (state),
        .score     (score),
        .hiscore   (hiscore)
    );

    game_sequencer #(
        .TICK_DIV   (2),
        .SCORE_DIV  (1),
        .DEAD_TICKS (1)
    ) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn2),
        .collision (coll2),
        .move_tick (s2_move),
        .jump_req  (s2_jump),
        .state     (s2_state),
        .score     (s2_score),
        .hiscore   (s2_hi)
    );

    assign dut_vec = {state, move_tick, jump_req, score, hiscore};

    // ---------------- reference model ----------------
    // Works in game events: clock edges since reset, button samples,
    // integer score and tick counts; BCD only appears when comparing.
    int         m_edges = 0;
    logic       m_b1 = 1'b0, m_b2 = 1'b0, m_b3 = 1'b0;
    logic [1:0] m_state = 2'd0;
    logic       m_move = 1'b0, m_jump = 1'b0;
    int         m_score = 0, m_hi = 0, m_run_ticks = 0, m_dead = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [35:0] exp_vec();
        return {m_state, m_move, m_jump, to_bcd(m_score), to_bcd(m_hi)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit tick_now, press_now;
        if (!rst_n) begin
            m_edges = 0; m_b1 = 0; m_b2 = 0; m_b3 = 0;
            m_state = 2'd0; m_move = 0; m_jump = 0;
            m_score = 0; m_hi = 0; m_run_ticks = 0; m_dead = 0;
        end else begin
            m_edges++;
            tick_now  = (m_edges % TICK_DIV) == 0;
            press_now = m_b2 & ~m_b3;
            m_b3 = m_b2; m_b2 = m_b1; m_b1 = btn_up;
            m_move = tick_now && (m_state == 2'd1);
            m_jump = press_now && (m_state == 2'd1);
            case (m_state)
                2'd0, 2'd3: if (press_now) begin
                    m_state = 2'd1; m_score = 0; m_run_ticks = 0;
                end
                2'd1: if (tick_now) begin
                    if (collision) begin
`ifdef GAME_SEQ_HISCORE_EN
                        if (m_score > m_hi) m_hi = m_score;
`endif
                        m_state = 2'd2; m_dead = 0;
                    end else begin
                        m_run_ticks++;
                        if ((m_run_ticks % SCORE_DIV) == 0 && m_score < 9999) m_score++;
                    end
                end
                default: if (tick_now) begin
                    m_dead++;
                    if (m_dead == DEAD_TICKS) m_state = 2'd3;
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_game(output bit ok);
        ok = 1'b0;
        btn_up = 1'b1;
        @(negedge clk);
        btn_up = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (state === 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; btn_up = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== 36'h0) $display("FAIL reset_outputs: got %h want %h", dut_vec, 36'h0);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_start();
        int  last_mt, n_mt;
        bit  gap_ok;
        btn_up = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) btn_up = 1'b0;
            n_checks++;
            if (state !== ((c >= 3) ? 2'd1 : 2'd0))
                $display("FAIL start_latency c%0d: got %0d want %0d", c, state, (c >= 3) ? 1 : 0);
            else n_pass++;
            n_checks++;
            if (jump_req !== 1'b0) $display("FAIL start_no_jump c%0d: got %b want 0", c, jump_req);
            else n_pass++;
        end
        n_mt = 0; last_mt = -1; gap_ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL start_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (move_tick === 1'b1) begin
                if (last_mt >= 0 && (c - last_mt) != TICK_DIV) gap_ok = 1'b0;
                last_mt = c;
                n_mt++;
            end
        end
        n_checks++;
        if (n_mt !== 4) $display("FAIL move_tick_count: got %0d want 4", n_mt);
        else n_pass++;
        n_checks++;
        if (gap_ok !== 1'b1) $display("FAIL move_tick_spacing: got %b want 1", gap_ok);
        else n_pass++;
    endtask

    task automatic test_jump();
        int pulses = 0;
        for (int p = 0; p < 3; p++) begin
            btn_up = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 1) btn_up = 1'b0;
                n_checks++;
                if (jump_req !== (c == 3))
                    $display("FAIL jump_timing p%0d c%0d: got %b want %b", p, c, jump_req, (c == 3));
                else n_pass++;
                if (jump_req === 1'b1) pulses++;
            end
        end
        n_checks++;
        if (pulses !== 3) $display("FAIL jump_count: got %0d want 3", pulses);
        else n_pass++;
    endtask

    task automatic test_score();
        bit ok;
        int cnt = 0;
        do_reset();
        start_game(ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL score_start: got %b want 1", ok);
        else n_pass++;
        for (int c = 0; c < 200 && cnt < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL score_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (move_tick === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 20) $display("FAIL score_ticks: got %0d want 20", cnt);
        else n_pass++;
        n_checks++;
        if (score !== 16'h0010) $display("FAIL score_20_ticks: got %h want 0010", score);
        else n_pass++;
    endtask

    task automatic test_hit();
        int saved, hit_cycles;
        bit found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if ((m_run_ticks % SCORE_DIV) == SCORE_DIV - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL hit_setup: got %b want 1", found);
        else n_pass++;
        saved = m_score;
        collision = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (state === 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        collision = 1'b0;
        n_checks++;
        if (found !== 1'b1) $display("FAIL hit_entry: got state %0d want 2", state);
        else n_pass++;
        n_checks++;
        if (score !== to_bcd(saved)) $display("FAIL hit_no_increment: got %h want %h", score, to_bcd(saved));
        else n_pass++;
        hit_cycles = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL hit_model c%0d: got %h want %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (state !== 2'd2) break;
            hit_cycles++;
            n_checks++;
            if (move_tick !== 1'b0) $display("FAIL hit_move_low c%0d: got %b want 0", c, move_tick);
            else n_pass++;
        end
        n_checks++;
        if (state !== 2'd3) $display("FAIL hit_to_over: got %0d want 3", state);
        else n_pass++;
        n_checks++;
        if (hit_cycles !== DEAD_TICKS * TICK_DIV)
            $display("FAIL hit_duration: got %0d want %0d", hit_cycles, DEAD_TICKS * TICK_DIV);
        else n_pass++;
    endtask

    task automatic test_hiscore();
        bit ok;
        int targets[2] = '{5, 3};
        do_reset();
        for (int g = 0; g < 2; g++) begin
            start_game(ok);
            n_checks++;
            if (ok !== 1'b1) $display("FAIL hi_start g%0d: got %b want 1", g, ok);
            else n_pass++;
            n_checks++;
            if (score !== 16'h0000) $display("FAIL hi_score_clear g%0d: got %h want 0000", g, score);
            else n_pass++;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec()) $display("FAIL hi_model g%0d c%0d: got %h want %h", g, c, dut_vec, exp_vec());
                else n_pass++;
                if (m_state == 2'd1 && m_score == targets[g]) collision = 1'b1;
                if (state === 2'd3) break;
            end
            collision = 1'b0;
            n_checks++;
            if (score !== to_bcd(targets[g])) $display("FAIL hi_final g%0d: got %h want %h", g, score, to_bcd(targets[g]));
            else n_pass++;
        end
        n_checks++;
`ifdef GAME_SEQ_HISCORE_EN
        if (hiscore !== 16'h0005) $display("FAIL hiscore_value: got %h want 0005", hiscore);
        else n_pass++;
`else
        if (hiscore !== 16'h0000) $display("FAIL hiscore_value: got %h want 0000", hiscore);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_game(ok);
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== 2'd1 || ok !== 1'b1) $display("FAIL mid_pre_run: got %0d want 1", state);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== 36'h0) $display("FAIL mid_async_reset: got %h want %h", dut_vec, 36'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== exp_vec() || state !== 2'd0)
            $display("FAIL mid_after_reset: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec()) $display("FAIL random_model p%0d c%0d: got %h want %h", ph, c, dut_vec, exp_vec());
                else n_pass++;
                case (ph)
                    0: begin
                        btn_up    = 1'($urandom_range(0, 1));
                        collision = ($urandom_range(0, 19) == 0);
                    end
                    1: begin
                        btn_up    = ($urandom_range(0, 7) == 0);
                        collision = ($urandom_range(0, 39) == 0);
                    end
                    default: begin
                        btn_up    = ~btn_up;
                        collision = ($urandom_range(0, 9) == 0);
                    end
                endcase
            end
        end
        btn_up = 1'b0;
        collision = 1'b0;
    endtask

    task automatic test_saturate();
        bit found = 1'b0;
        btn2 = 1'b1;
        @(negedge clk);
        btn2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s2_score !== 16'h0000) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1 || s2_state !== 2'd1) $display("FAIL sat_start: got state %0d score %h", s2_state, s2_score);
        else n_pass++;
        for (int k = 1; k <= 10005; k++) begin
            n_checks++;
            if (s2_score !== to_bcd((k > 9999) ? 9999 : k))
                $display("FAIL sat_score k%0d: got %h want %h", k, s2_score, to_bcd((k > 9999) ? 9999 : k));
            else n_pass++;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_jump();
        test_score();
        test_hit();
        test_hiscore();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
